unidad_muldiv: RTL and testbench



---
 rtl/unidad_muldiv.sv | 168 ++++++++++++++++
 tb/tb_unidad_muldiv.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/unidad_muldiv.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, HI/LO result (MULDIV_SIGNED_EN enables MULT/DIV).
// Latency: WIDTH+2 cycles from the accepted START_MD edge to the DONE_MD pulse.
// Backpressure: START_MD is taken only in IDLE; requests while BUSY_MD or during DONE are dropped.
module unidad_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START_MD,
  input  logic [1:0]       OP_MD,
  input  logic [WIDTH-1:0] A_MD,
  input  logic [WIDTH-1:0] B_MD,
  output logic             BUSY_MD,
  output logic             DONE_MD,
  output logic             DIV0_MD,
  output logic [WIDTH-1:0] HI_MD,
  output logic [WIDTH-1:0] LO_MD
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     r_sh;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               neg_p;
  logic               neg_r;
  logic [WIDTH-1:0]   hi_div0;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               div_by_zero;

`ifdef MULDIV_SIGNED_EN
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] a_orig;
  logic             a_neg;
  logic             b_neg;

  assign a_neg   = OP_MD[0] & A_MD[WIDTH-1];
  assign b_neg   = OP_MD[0] & B_MD[WIDTH-1];
  assign a_mag   = a_neg ? (~A_MD + 1'b1) : A_MD;
  assign b_mag   = b_neg ? (~B_MD + 1'b1) : B_MD;
  assign neg_p   = sa ^ sb;
  assign neg_r   = sa;
  assign hi_div0 = a_orig;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sa     <= 1'b0;
      sb     <= 1'b0;
      a_orig <= '0;
    end else if (state == S_IDLE && START_MD) begin
      sa     <= a_neg;
      sb     <= b_neg;
      a_orig <= A_MD;
    end
  end
`else
  logic unused_op0;

  assign unused_op0 = OP_MD[0];
  assign a_mag      = A_MD;
  assign b_mag      = B_MD;
  assign neg_p      = 1'b0;
  assign neg_r      = 1'b0;
  assign hi_div0    = ma;
`endif

  // Multiply adds the multiplicand into the upper half while shifting B out of the low half.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, ma};
  // Divide shifts {rem, dividend} left; trial's MSB is the borrow of rem - divisor.
  assign r_sh    = acc[2*WIDTH-1:WIDTH-1];
  assign trial   = r_sh - {1'b0, mb};

  always_comb begin
    acc_nxt = acc;
    if (is_div) begin
      if (trial[WIDTH])
        acc_nxt = {r_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      if (acc[0])
        acc_nxt = {mul_sum, acc[WIDTH-1:1]};
      else
        acc_nxt = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
    end
  end

  assign prod        = neg_p ? (~acc + 1'b1) : acc;
  assign quo         = neg_p ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem         = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  assign div_by_zero = is_div && (mb == '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      ma      <= '0;
      mb      <= '0;
      acc     <= '0;
      BUSY_MD <= 1'b0;
      DONE_MD <= 1'b0;
      DIV0_MD <= 1'b0;
      HI_MD   <= '0;
      LO_MD   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          DONE_MD <= 1'b0;
          if (START_MD) begin
            is_div  <= OP_MD[1];
            ma      <= a_mag;
            mb      <= b_mag;
            acc     <= OP_MD[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
            cnt     <= CW'(WIDTH - 1);
            BUSY_MD <= 1'b1;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0)
            state <= S_FIN;
        end
        S_FIN: begin
          if (div_by_zero) begin
            HI_MD   <= hi_div0;
            LO_MD   <= '1;
            DIV0_MD <= 1'b1;
          end else if (is_div) begin
            HI_MD   <= rem;
            LO_MD   <= quo;
            DIV0_MD <= 1'b0;
          end else begin
            HI_MD   <= prod[2*WIDTH-1:WIDTH];
            LO_MD   <= prod[WIDTH-1:0];
            DIV0_MD <= 1'b0;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          DONE_MD <= 1'b1;
          BUSY_MD <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unidad_muldiv.sv
// Bench for unidad_muldiv: cycle-level arithmetic model checked every cycle, plus hand-computed vectors.
module tb_unidad_muldiv;

  logic        CLK;
  logic        RST_N;
  logic        START_MD;
  logic [1:0]  OP_MD;
  logic [31:0] A_MD;
  logic [31:0] B_MD;
  logic        BUSY_MD;
  logic        DONE_MD;
  logic        DIV0_MD;
  logic [31:0] HI_MD;
  logic [31:0] LO_MD;

  int checks = 0;
  int errors = 0;

  unidad_muldiv #(.WIDTH(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .START_MD(START_MD), .OP_MD(OP_MD),
    .A_MD(A_MD), .B_MD(B_MD), .BUSY_MD(BUSY_MD), .DONE_MD(DONE_MD),
    .DIV0_MD(DIV0_MD), .HI_MD(HI_MD), .LO_MD(LO_MD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Result of an operation computed straight from the arithmetic definition.
  task automatic model_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo, output logic d0);
    logic        sgn;
    logic [63:0] p;
    longint      sa, sb, q, r;
`ifdef MULDIV_SIGNED_EN
    sgn = op[0];
`else
    sgn = 1'b0;
`endif
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    d0 = 1'b0;
    if (!op[1]) begin
      p  = 64'(sa * sb);
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
      d0 = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endtask

  // m_t: edges since the accepted start (-1 idle); results become visible 33 edges in.
  int          m_t = -1;
  logic [31:0] p_hi, p_lo, exp_hi, exp_lo;
  logic        p_d0, exp_d0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_t    = -1;
      exp_hi = '0;
      exp_lo = '0;
      exp_d0 = 1'b0;
    end else if (m_t >= 0 && m_t < 34) begin
      m_t++;
      if (m_t == 33) begin
        exp_hi = p_hi;
        exp_lo = p_lo;
        exp_d0 = p_d0;
      end
    end else if (START_MD) begin
      m_t = 0;
      model_res(OP_MD, A_MD, B_MD, p_hi, p_lo, p_d0);
    end else begin
      m_t = -1;
    end
  end

  bit cmp_en = 1'b0;

  always begin
    @(posedge CLK);
    #1;
    if (cmp_en && RST_N) begin
      chk("cyc_busy", 64'(BUSY_MD), 64'(m_t >= 0 && m_t <= 33));
      chk("cyc_done", 64'(DONE_MD), 64'(m_t == 34));
      chk("cyc_hi",   64'(HI_MD),   64'(exp_hi));
      chk("cyc_lo",   64'(LO_MD),   64'(exp_lo));
      chk("cyc_div0", 64'(DIV0_MD), 64'(exp_d0));
    end
  end

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic ed0, input bit repulse);
    int lat;
    bit got;
    int extra;
    lat = -1;
    got = 1'b0;
    @(negedge CLK);
    START_MD = 1'b1;
    OP_MD    = op;
    A_MD     = a;
    B_MD     = b;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (DONE_MD) begin
        got = 1'b1;
        lat = i;
        break;
      end
      START_MD = repulse && (i == 5 || i == 20);
      OP_MD    = 2'($urandom);
      A_MD     = $urandom;
      B_MD     = $urandom;
    end
    START_MD = 1'b0;
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout actual=no_done expected=done_within_60", nm);
    end else begin
      chk({nm, "_lat"},  64'(lat),     64'd34);
      chk({nm, "_hi"},   64'(HI_MD),   64'(ehi));
      chk({nm, "_lo"},   64'(LO_MD),   64'(elo));
      chk({nm, "_div0"}, 64'(DIV0_MD), 64'(ed0));
    end
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (DONE_MD) extra++;
    end
    chk({nm, "_one_pulse"}, 64'(extra), 64'd0);
  endtask

  initial begin
    RST_N    = 1'b0;
    START_MD = 1'b0;
    OP_MD    = 2'b00;
    A_MD     = '0;
    B_MD     = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 64'(BUSY_MD), 64'd0);
    chk("rst_done", 64'(DONE_MD), 64'd0);
    chk("rst_div0", 64'(DIV0_MD), 64'd0);
    chk("rst_hi",   64'(HI_MD),   64'd0);
    chk("rst_lo",   64'(LO_MD),   64'd0);
    RST_N  = 1'b1;
    cmp_en = 1'b1;
    @(negedge CLK);

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
`ifdef MULDIV_SIGNED_EN
    run_op("mult_m2x3", 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
    run_op("mult_7xm3", 2'b01, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
`else
    run_op("mult_m2x3", 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0, 1'b0);
    run_op("mult_7xm3", 2'b01, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0, 1'b0);
`endif
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
`ifdef MULDIV_SIGNED_EN
    run_op("div_m7_2",  2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("div_7_m2",  2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
`else
    run_op("div_m7_2",  2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0, 1'b0);
    run_op("div_7_m2",  2'b11, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd0, 1'b0, 1'b0);
    run_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
`endif
    run_op("divu_by0",  2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("multu_3x4", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b0);
    run_op("div_m7_by0", 2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("divu_repulse", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);

    // Abort a multiply mid-flight with reset, then run a clean one.
    @(negedge CLK);
    START_MD = 1'b1;
    OP_MD    = 2'b00;
    A_MD     = 32'h0000_1234;
    B_MD     = 32'h0000_5678;
    @(negedge CLK);
    START_MD = 1'b0;
    repeat (9) @(negedge CLK);
    chk("abort_busy_before", 64'(BUSY_MD), 64'd1);
    RST_N = 1'b0;
    #1;
    chk("abort_busy", 64'(BUSY_MD), 64'd0);
    chk("abort_done", 64'(DONE_MD), 64'd0);
    chk("abort_div0", 64'(DIV0_MD), 64'd0);
    chk("abort_hi",   64'(HI_MD),   64'd0);
    chk("abort_lo",   64'(LO_MD),   64'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    run_op("multu_6x7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0);

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
